// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code decoder: synchronizes the receiver byte strobe, tracks E0/F0 prefixes,
// and queues {ext, break, code} key events in a show-ahead FIFO. Optional: KEY_REPEAT_FILTER_EN.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_valid,
  input  logic [7:0]                    ps2_byte,
  input  logic                          ev_rd,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_break,
  output logic                          ev_empty,
  output logic                          ev_full,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // Handshake: the receiver holds ps2_valid high with ps2_byte stable for a whole frame;
  // the consumer pops the head event with ev_rd while ev_empty=0 (one pop per cycle).

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   strobe;
  state_t                 state_q, state_d;
  logic                   ev_valid, ev_ext_c, ev_brk_c;
  logic                   push_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ps2_valid};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign strobe = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ev_valid = 1'b0;
    ev_ext_c = 1'b0;
    ev_brk_c = 1'b0;
    if (strobe) begin
      if (ps2_byte == 8'hE0) begin
        if (state_q == IDLE) state_d = EXT;
      end else if (ps2_byte == 8'hF0) begin
        if (state_q == IDLE)     state_d = BRK;
        else if (state_q == EXT) state_d = EXT_BRK;
      end else if (ps2_byte == 8'h00 || ps2_byte == 8'hAA || ps2_byte == 8'hEE ||
                   ps2_byte == 8'hFA || ps2_byte == 8'hFE || ps2_byte == 8'hFF) begin
        // Controller replies (ACK, BAT, echo, resend, error) are not key events.
        state_d = IDLE;
      end else begin
        ev_valid = 1'b1;
        ev_ext_c = (state_q == EXT) || (state_q == EXT_BRK);
        ev_brk_c = (state_q == BRK) || (state_q == EXT_BRK);
        state_d  = IDLE;
      end
    end
  end

`ifdef KEY_REPEAT_FILTER_EN
  logic       last_valid;
  logic       last_ext;
  logic [7:0] last_code;
  logic       last_match;

  assign last_match = last_valid && (last_ext == ev_ext_c) && (last_code == ps2_byte);

  always_comb begin
    push_req = ev_valid;
    if (ev_valid && !ev_brk_c && last_match) push_req = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_valid <= 1'b0;
      last_ext   <= 1'b0;
      last_code  <= 8'h00;
    end else if (ev_valid) begin
      if (ev_brk_c) begin
        if (last_match) last_valid <= 1'b0;
      end else if (!last_match) begin
        last_valid <= 1'b1;
        last_ext   <= ev_ext_c;
        last_code  <= ps2_byte;
      end
    end
  end
`else
  assign push_req = ev_valid;
`endif

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_d;
  logic          do_pop, do_push;
  logic [9:0]    head;

  assign do_pop  = ev_rd & ~ev_empty;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign do_push = push_req & (~ev_full | do_pop);

  always_comb begin
    count_d = ev_count;
    if (do_push && !do_pop)      count_d = ev_count + CW'(1);
    else if (do_pop && !do_push) count_d = ev_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {ev_ext_c, ev_brk_c, ps2_byte};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ev_count <= '0;
      ev_empty <= 1'b1;
      ev_full  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      ev_count <= count_d;
      ev_empty <= (count_d == '0);
      ev_full  <= (count_d == CW'(FIFO_DEPTH));
      if (push_req && ev_full && !do_pop) overflow <= 1'b1;
    end
  end

  assign head     = mem[rd_ptr];
  assign ev_ext   = ev_empty ? 1'b0  : head[9];
  assign ev_break = ev_empty ? 1'b0  : head[8];
  assign ev_code  = ev_empty ? 8'h00 : head[7:0];

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: prefixes, discards, FIFO boundaries, reset, repeat filter.
module tb_ps2_scancode_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_valid = 1'b0;
  logic [7:0] ps2_byte = 8'h00;
  logic       ev_rd = 1'b0;
  logic [7:0] ev_code;
  logic       ev_ext, ev_break, ev_empty, ev_full, overflow;
  logic [3:0] ev_count;

  int n_cmp = 0;
  int n_bad = 0;

  ps2_scancode_decoder #(.FIFO_DEPTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ps2_valid(ps2_valid), .ps2_byte(ps2_byte), .ev_rd(ev_rd),
    .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break), .ev_empty(ev_empty),
    .ev_full(ev_full), .ev_count(ev_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    ps2_byte  = b;
    ps2_valid = 1'b1;
    repeat (4) @(negedge clk);
    ps2_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk);
    ev_rd = 1'b1;
    @(negedge clk);
    ev_rd = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [7:0] code, input logic ext, input logic brk);
    check({tag, "_code"}, ev_code, code);
    check({tag, "_ext"}, ev_ext, ext);
    check({tag, "_brk"}, ev_break, brk);
  endtask

  initial begin
    do_reset();
    check("rst_empty", ev_empty, 1);
    check("rst_full", ev_full, 0);
    check("rst_count", ev_count, 0);
    check("rst_ovf", overflow, 0);
    check_head("rst", 8'h00, 0, 0);

    // Single make with latency: write lands at the third edge after ps2_valid rises.
    @(negedge clk);
    ps2_byte  = 8'h1C;
    ps2_valid = 1'b1;
    @(negedge clk);
    check("lat_e1_empty", ev_empty, 1);
    @(negedge clk);
    check("lat_e2_empty", ev_empty, 1);
    @(negedge clk);
    check("lat_e3_empty", ev_empty, 0);
    check_head("make", 8'h1C, 0, 0);
    check("make_count", ev_count, 1);
    repeat (5) @(negedge clk);
    check("held_level_count", ev_count, 1);
    ps2_valid = 1'b0;
    repeat (3) @(negedge clk);
    pop();
    check("pop_empty", ev_empty, 1);
    check("pop_code", ev_code, 8'h00);

    // Break and extended break.
    send_byte(8'hF0);
    check("f0_no_event", ev_empty, 1);
    send_byte(8'h1C);
    check_head("brk", 8'h1C, 0, 1);
    check("brk_count", ev_count, 1);
    pop();
    send_byte(8'hE0);
    send_byte(8'hF0);
    check("e0f0_no_event", ev_empty, 1);
    send_byte(8'h75);
    check_head("extbrk", 8'h75, 1, 1);
    check("extbrk_count", ev_count, 1);
    pop();

    // Overflow: nine distinct makes into a depth-8 FIFO.
    do_reset();
    for (int i = 0; i < 9; i++) send_byte(8'h15 + 8'(i));
    check("ovf_full", ev_full, 1);
    check("ovf_count", ev_count, 8);
    check("ovf_flag", overflow, 1);
    check("ovf_head", ev_code, 8'h15);
    for (int i = 0; i < 8; i++) begin
      check("drain_code", ev_code, 8'h15 + 8'(i));
      pop();
    end
    check("drain_empty", ev_empty, 1);
    check("drain_ovf_sticky", overflow, 1);

    // Push and pop in the same cycle while full.
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(8'h15 + 8'(i));
    check("pp_full_before", ev_full, 1);
    @(negedge clk);
    ps2_byte  = 8'h1D;
    ps2_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ev_rd = 1'b1;
    @(negedge clk);
    ev_rd = 1'b0;
    check("pp_count", ev_count, 8);
    check("pp_full", ev_full, 1);
    check("pp_ovf", overflow, 0);
    check("pp_head", ev_code, 8'h16);
    repeat (2) @(negedge clk);
    ps2_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 7; i++) pop();
    check("pp_tail", ev_code, 8'h1D);

    // Controller replies are discarded and cancel a pending prefix.
    do_reset();
    send_byte(8'hE0);
    send_byte(8'hAA);
    send_byte(8'h1C);
    check_head("disc", 8'h1C, 0, 0);
    check("disc_count", ev_count, 1);
    pop();
    send_byte(8'hFA);
    send_byte(8'hEE);
    check("fa_ee_empty", ev_empty, 1);

    // Reset mid-sequence drops the F0 prefix and queued events.
    send_byte(8'h2B);
    send_byte(8'hF0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_empty", ev_empty, 1);
    check("midrst_count", ev_count, 0);
    check("midrst_code", ev_code, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    send_byte(8'h1C);
    check_head("after_rst", 8'h1C, 0, 0);
    check("after_rst_count", ev_count, 1);

    // Typematic repeat sequence.
    do_reset();
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    send_byte(8'h1C);
`ifdef KEY_REPEAT_FILTER_EN
    check("rep_count", ev_count, 3);
    check_head("rep0", 8'h1C, 0, 0);
    pop();
    check_head("rep1", 8'h1C, 0, 1);
    pop();
    check_head("rep2", 8'h1C, 0, 0);
`else
    check("rep_count", ev_count, 5);
    for (int i = 0; i < 3; i++) begin
      check_head("rep_make", 8'h1C, 0, 0);
      pop();
    end
    check_head("rep_brk", 8'h1C, 0, 1);
    pop();
    check_head("rep_last", 8'h1C, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes the byte stream from the PS/2 keyboard receiver (`data_valid` plus the 8-bit `out_reg` byte) and turns raw scan-code bytes into key events. Each event is a code, an extended flag and a break flag. Events are buffered in a small show-ahead FIFO so a downstream consumer (display, UART, control logic) can read them at its own pace on the system clock. The block sits directly downstream of the `ps2` receiver, in place of feeding its byte straight to the 7-segment transcoders.

## Interface
- `FIFO_DEPTH`, 8, event FIFO depth; must be a power of 2, ≥2.
- `SYNC_STAGES`, 2, flip-flop stages synchronizing `ps2_valid` into `clk`; ≥2.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `ps2_valid`  in  1  receiver byte-ready flag; asynchronous to `clk`, level-held until the next frame.
- `ps2_byte`  in  8  receiver byte; quasi-static while `ps2_valid` is high.
- `ev_rd`  in  1  pop the head event; ignored when `ev_empty`=1.
- `ev_code`  out  8  head event scan code; 0 when empty.
- `ev_ext`  out  1  head event was E0-prefixed; 0 when empty.
- `ev_break`  out  1  head event is a key release; 0 when empty.
- `ev_empty`  out  1  FIFO empty.
- `ev_full`  out  1  FIFO full.
- `ev_count`  out  $clog2(FIFO_DEPTH)+1  number of stored events.
- `overflow`  out  1  sticky: an event was dropped because the FIFO was full.

## Operation
- Reset values: all outputs 0 except `ev_empty`=1. FSM is in IDLE, the synchronizer and edge register are cleared, and the FIFO is empty.
- `ps2_valid` passes through the `SYNC_STAGES` synchronizer. A rising edge on the synchronized signal is a byte strobe; `ps2_byte` is sampled directly, without synchronization, on that strobe.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Handling of each strobed byte b:
  - b=0xE0: IDLE→EXT; in any other state, stay in the current state and take no other action.
  - b=0xF0: IDLE→BRK, EXT→EXT_BRK; in BRK or EXT_BRK, stay in the current state.
  - b ∈ {0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF}: discarded; go to IDLE; no event.
  - Any other b: push event {ext, brk, b}, with ext=1 in EXT/EXT_BRK and brk=1 in BRK/EXT_BRK; go to IDLE.
- FIFO: 10-bit entries, show-ahead. The head entry is driven on `ev_code`/`ev_ext`/`ev_break` whenever it is not empty.
  - `ev_rd` with the FIFO non-empty pops one entry per cycle.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
  - Push while full (and no pop in the same cycle): the event is dropped, `overflow` is set and stays set until reset, and FIFO contents are unchanged.
  - Simultaneous push and pop when full: both happen; `ev_count` stays at `FIFO_DEPTH` and `overflow` is not set.
  - Simultaneous push and pop when empty: the pop is ignored; the push happens and `ev_count` becomes 1.
- `ev_full` = (`ev_count`==`FIFO_DEPTH`) and `ev_empty` = (`ev_count`==0); both are registered and consistent with `ev_count`.
- Reset mid-sequence (for example after F0): the pending prefix is discarded, and the next code byte produces a plain make event.

## Timing
- `ps2_valid` is first sampled high at edge 1. The synchronized strobe is high during the cycle after edge `SYNC_STAGES`. The event is written at edge `SYNC_STAGES`+1, so `ev_empty` falls after edge `SYNC_STAGES`+1 (3 edges by default).
- `ps2_byte` must be stable from the rise of `ps2_valid` through the consuming edge. The PS/2 frame period (≥~600 µs) guarantees this for any `clk` ≥1 MHz.
- One strobe per `ps2_valid` rising edge. A level held high produces no further strobes.
- Pop: the head outputs update and `ev_count` decrements after the edge at which `ev_rd`=1 and `ev_empty`=0.
- No combinational path from any input to any output.

## Configuration
- `KEY_REPEAT_FILTER_EN` defined:
  - The block holds a last-make register {valid, ext, code}. A make event equal to the stored {ext, code} while valid=1 is dropped (typematic repeat).
  - A break event with matching {ext, code} clears valid.
  - Any other make event overwrites the register and sets valid.
  - Reset clears valid.
- Not defined: every make is pushed and no last-make register exists.

## Test plan
- Bytes 0x1C → one event: `ev_code`=0x1C, `ev_ext`=0, `ev_break`=0, `ev_count`=1; `ev_rd` pulse → `ev_empty`=1.
- Bytes 0xF0, 0x1C → one event: 0x1C, ext=0, brk=1. Bytes 0xE0, 0xF0, 0x75 → one event: 0x75, ext=1, brk=1. No events on prefix bytes.
- Nine distinct makes 0x15..0x1D with no reads (depth 8) → `ev_full`=1, `ev_count`=8, `overflow`=1, head=0x15; eight reads return 0x15..0x1C in order. In a separate run, a push and a pop in the same cycle while full → `overflow` stays 0.
- Bytes 0xE0, 0xAA, 0x1C → one event 0x1C with ext=0. Bytes 0xFA and 0xEE alone → no events.
- Bytes 0xF0, then `rst` pulse, then 0x1C → outputs at reset value during `rst`, then one event 0x1C with brk=0.
- 0x1C, 0x1C, 0x1C, 0xF0, 0x1C, 0x1C: with `KEY_REPEAT_FILTER_EN` → 3 events (make, break, make); without it → 5 events.
